// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Sequences one 16-bit load or store from the core's execute stage onto an
// 8-bit data memory. Each word access becomes two little-endian byte
// accesses: the low byte at A and the high byte at A+1, where A+1 wraps
// modulo 2^ADDR_W. Loads and stores both complete with one response beat.
//
// Optional feature macro: LSU_BYTE_ACCESS_EN
//   defined   : req_size is honoured. A byte op uses only the LO access.
//               Byte loads are zero-extended. Byte stores write wdata[7:0].
//   undefined : req_size is ignored and every op is a 16-bit word op.
//
// Handshakes (request and response channels): a beat transfers on a rising
// edge where valid and ready are both high. A source may drop valid without
// a transfer. Once raised, resp_valid and resp_data stay stable until the
// consumer takes the beat.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_*           request channel (valid/ready, write, size, addr, wdata)
//   resp_*          response channel (valid/ready, data; 0 for stores)
//   mem_*           byte-wide data memory port. mem_read_data is combinational
//                   and is valid in the same cycle that mem_read is high.
//   dbg_state       current FSM state, for observation
//                   (0=IDLE, 1=LO, 2=HI, 3=RESP)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [7:0]        mem_read_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_write;
  logic [15:0]       r_data;

  logic              w_accept;
  logic              w_word;
  logic [ADDR_W-1:0] w_addr_hi;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_addr_hi = r_addr + ADDR_W'(1);   // natural wrap: FF -> 00
  assign dbg_state = r_state;

`ifdef LSU_BYTE_ACCESS_EN
  logic r_size;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size <= 1'b0;
    end else if (w_accept) begin
      r_size <= req_size;
    end
  end

  assign w_word = r_size;
`else
  // Size is ignored in this build; every op is a word op.
  logic w_unused_size;
  assign w_unused_size = req_size;
  assign w_word        = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (req_valid)  w_next_state = S_LO;
      S_LO:   w_next_state = w_word ? S_HI : S_RESP;
      S_HI:   w_next_state = S_RESP;
      S_RESP: if (resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. These decode only from the registered state and latches,
  // so there is no input-to-output path.
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = 16'h0000;
    mem_address    = '0;
    mem_write_data = 8'h00;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_LO: begin
        mem_address = r_addr;
        if (r_write) begin
          mem_write      = 1'b1;
          mem_write_data = r_wdata[7:0];
        end else begin
          mem_read = 1'b1;
        end
      end
      S_HI: begin
        mem_address = w_addr_hi;
        if (r_write) begin
          mem_write      = 1'b1;
          mem_write_data = r_wdata[15:8];
        end else begin
          mem_read = 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_data  = r_write ? 16'h0000 : r_data;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latches and the load data assembly register. r_data is cleared
  // on accept, so a byte load leaves the upper byte zero (zero extension).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= 16'h0000;
      r_write <= 1'b0;
      r_data  <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_write <= req_write;
            r_data  <= 16'h0000;
          end
        end
        S_LO: begin
          if (!r_write) r_data[7:0] <= mem_read_data;
        end
        S_HI: begin
          if (!r_write) r_data[15:8] <= mem_read_data;
        end
        default: begin
          r_data <= r_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// Bench for load_store_unit. A byte-array memory sits on the mem_* port. A
// reference memory plus the per-op rules (little-endian split, A+1 wrap,
// zero-extended byte loads) predict every response, latency and write beat.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_size = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic [7:0]  mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  mem_read_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // Environment memory: combinational read, write on the rising edge.
  logic [7:0] mem      [256];
  logic [7:0] init_mem [256];
  logic       load_mem = 1'b0;

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (mem_write) begin
      mem[mem_address] <= mem_write_data;
    end
  end

  // Observed write beats {addr, data} with the cycle each happened in.
  logic [15:0] bus_q[$];
  int          bus_cyc_q[$];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && mem_write) begin
      bus_q.push_back({mem_address, mem_write_data});
      bus_cyc_q.push_back(cyc);
    end
  end

  // Reference model state and scoreboard.
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read and write strobes must never be high together.
  always @(negedge clk) begin
    if (!rst && (mem_read || mem_write))
      check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
  end

  task automatic check_trace();
    int n;
    check("trace_len", bus_q.size(), exp_q.size());
    n = (bus_q.size() < exp_q.size()) ? bus_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("trace_beat", {16'd0, bus_q[i]}, {16'd0, exp_q[i]});
      if (i > 0) check("trace_adjacent", bus_cyc_q[i] - bus_cyc_q[i-1], 1);
    end
    bus_q.delete();
    bus_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_data"}, {16'd0, resp_data}, 32'd0);
    check({tag, "_mem_bus"}, {14'd0, mem_read, mem_write, mem_address, mem_write_data}, 32'd0);
  endtask

  // Driver: one full request/response transaction, called with the unit idle
  // at #1 after a rising edge. While the response is held off, a conflicting
  // store request is presented and must not be taken.
  task automatic run_op(input logic wr, input logic sz, input logic [7:0] a,
                        input logic [15:0] wd, input int rr_delay,
                        output logic [15:0] got);
    logic        is_word;
    logic [7:0]  a1;
    logic [15:0] exp_data;
    int          exp_lat;
    int          lat;
`ifdef LSU_BYTE_ACCESS_EN
    is_word = sz;
`else
    is_word = 1'b1;
`endif
    a1      = a + 8'd1;
    exp_lat = is_word ? 2 : 1;
    if (wr) begin
      exp_data = 16'h0000;
      exp_q.push_back({a, wd[7:0]});
      if (is_word) exp_q.push_back({a1, wd[15:8]});
    end else begin
      exp_data = is_word ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
    end

    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);
    check("busy_req_ready", {31'd0, req_ready}, 32'd0);

    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 10);
    check("resp_latency", lat, exp_lat);
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_data", {16'd0, resp_data}, {16'd0, exp_data});
    check("resp_mem_quiet", {14'd0, mem_read, mem_write, mem_address, mem_write_data}, 32'd0);
    got = resp_data;

    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 1'b1;
    for (int k = 0; k < rr_delay; k++) begin
      @(posedge clk);
      #1;
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_resp_data", {16'd0, resp_data}, {16'd0, exp_data});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_taken", {31'd0, resp_valid}, 32'd0);
    check("back_to_idle", {31'd0, req_ready}, 32'd1);

    if (wr) begin
      ref_mem[a] = wd[7:0];
      if (is_word) ref_mem[a1] = wd[15:8];
    end
    check_trace();
  endtask

  // Watchdog: the stimulus is bounded, but guard against a wedged run.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] got;
    logic [7:0]  old11;
    logic [7:0]  old03;
    logic        r_wr;
    logic        r_sz;
    logic [7:0]  r_a;

    for (int i = 0; i < 256; i++) begin
      init_mem[i] = 8'($urandom);
      ref_mem[i]  = init_mem[i];
    end

    // Reset values, before any clock edge and during reset.
    #1;
    check_reset_outputs("reset0");
    load_mem = 1'b1;
    @(posedge clk);
    #1;
    load_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset1");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("idle");

    // Reset asserted during HI of a word store to 8'h10.
    old11 = ref_mem[8'h11];
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 1'b1;
    req_addr  = 8'h10;
    req_wdata = 16'hC35A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("lo_write", {22'd0, mem_write, mem_address, mem_write_data}, {22'd0, 1'b1, 8'h10, 8'h5A});
    @(posedge clk);
    #1;
    check("hi_write", {22'd0, mem_write, mem_address, mem_write_data}, {22'd0, 1'b1, 8'h11, 8'hC3});
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_hi_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("no_resp_after_reset", {31'd0, resp_valid}, 32'd0);
    end
    check("abort_lo_byte", {24'd0, mem[8'h10]}, 32'h5A);
    check("abort_hi_byte", {24'd0, mem[8'h11]}, {24'd0, old11});
    ref_mem[8'h10] = 8'h5A;
    exp_q.push_back({8'h10, 8'h5A});
    check_trace();

    // Word store then word load at 8'h04.
    run_op(1'b1, 1'b1, 8'h04, 16'hBEEF, 0, got);
    check("beef_store_resp", {16'd0, got}, 32'd0);
    run_op(1'b0, 1'b1, 8'h04, 16'h0000, 1, got);
    check("beef_load", {16'd0, got}, 32'hBEEF);

    // Word access wrapping from 8'hFF to 8'h00.
    run_op(1'b1, 1'b1, 8'hFF, 16'h1234, 0, got);
    check("wrap_lo_byte", {24'd0, mem[8'hFF]}, 32'h34);
    check("wrap_hi_byte", {24'd0, mem[8'h00]}, 32'h12);
    run_op(1'b0, 1'b1, 8'hFF, 16'h0000, 2, got);
    check("wrap_load", {16'd0, got}, 32'h1234);

    // Back-pressure: response held off for 5 cycles with a competing request.
    run_op(1'b0, 1'b1, 8'h04, 16'h0000, 5, got);
    check("backpressure_load", {16'd0, got}, 32'hBEEF);

    // Byte-size request at 8'h02.
    old03 = ref_mem[8'h03];
    run_op(1'b1, 1'b0, 8'h02, 16'h77A5, 0, got);
    check("byte_store_lo", {24'd0, mem[8'h02]}, 32'hA5);
`ifdef LSU_BYTE_ACCESS_EN
    check("byte_store_hi_untouched", {24'd0, mem[8'h03]}, {24'd0, old03});
    run_op(1'b0, 1'b0, 8'h02, 16'h0000, 1, got);
    check("byte_load", {16'd0, got}, 32'h00A5);
`else
    check("byte_req_full_word", {24'd0, mem[8'h03]}, 32'h77);
    run_op(1'b0, 1'b0, 8'h02, 16'h0000, 1, got);
    check("byte_req_word_load", {16'd0, got}, 32'h77A5);
`endif

    // Randomized ops over a small address window plus the wrap address.
    for (int n = 0; n < 40; n++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_sz = 1'($urandom_range(0, 1));
      r_a  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      run_op(r_wr, r_sz, r_a, 16'($urandom), $urandom_range(0, 3), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store sequencer between the 16-bit core's execute stage and the 8-bit-wide data memory. It accepts one load or store request at a time on a valid/ready handshake. Each 16-bit word access is split into two little-endian byte accesses on the memory port. The result or completion is returned on a valid/ready response channel. The unit is the sole initiator on the data-memory port.

## Interface
Parameters:
- ADDR_W, 8, byte address width on both the request and memory sides.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  1  1 = 16-bit word, 0 = byte. Only honoured when LSU_BYTE_ACCESS_EN is defined.
- req_addr  in  ADDR_W  byte address of the low byte.
- req_wdata  in  16  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  16  load data; 16'h0000 for stores.
- mem_address  out  ADDR_W  memory byte address.
- mem_write_data  out  8  memory write byte.
- mem_write  out  1  memory write strobe. The memory writes on the rising clock edge while this is high.
- mem_read  out  1  memory read enable.
- mem_read_data  in  8  combinational read data, valid in the same cycle mem_read is high.

## Operation
- States: IDLE, LO, HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch addr, wdata, write and size; go to LO.
- LO:
  - Access the latched address A.
  - Store: mem_write=1, mem_write_data=wdata[7:0].
  - Load: mem_read=1; capture mem_read_data into data[7:0] at the edge.
  - Next state: HI for a word access, RESP for a byte access.
- HI:
  - Access A+1, computed modulo 2^ADDR_W, so A=8'hFF wraps to 8'h00.
  - Store: mem_write_data=wdata[15:8].
  - Load: capture mem_read_data into data[15:8].
  - Next state: RESP.
- RESP:
  - resp_valid=1, resp_data=data for a load and 0 for a store.
  - Outputs stay stable until resp_ready; on resp_valid & resp_ready go to IDLE.
- Byte load: zero-extends, resp_data={8'h00, byte}.
- mem_read and mem_write are never high together, and both are 0 outside LO/HI.
- mem_address and mem_write_data are 0 in IDLE and RESP.
- All mem_* and resp_* outputs decode from registered state only; no input-to-output combinational path exists.
- Misaligned word addresses are legal and get no special treatment.

## Timing
- Reset: asynchronous entry to IDLE, and data/latches cleared. Output values during reset:
  - req_ready=1
  - resp_valid=0, resp_data=0
  - mem_read=0, mem_write=0, mem_address=0, mem_write_data=0
- Reset during LO/HI: the op is abandoned and no response is issued. A word store interrupted in HI leaves the low byte written.
- Word op: accept edge E0; LO in cycle E0–E1; HI in cycle E1–E2; resp_valid high from E2. The earliest response handshake is E3, after which the next request can be accepted at E4.
- Byte op: resp_valid high from E1, one cycle earlier than a word op.
- Back-to-back requests: at most one in flight, and req_ready stays 0 until the unit has returned to IDLE.
- req_valid may drop without a handshake; nothing is latched in that case.

## Configuration
- LSU_BYTE_ACCESS_EN defined: req_size is honoured, so byte ops use the LO state only, with zero-extended loads and stores that write wdata[7:0] only.
- Not defined: req_size is ignored, every op is a 16-bit word op, and the LO→RESP path is absent.

## Test plan
- Reset asserted mid-HI of a store to A=8'h10: outputs immediately take their reset values, and no resp_valid follows. Memory[8'h10] holds the low byte and memory[8'h11] is unchanged.
- Word store 16'hBEEF to A=8'h04, then word load from A=8'h04:
  - The store drives mem_write in two consecutive cycles: addr 04/EF, then addr 05/BE.
  - The store responds with resp_data=0.
  - The load returns resp_data=16'hBEEF, with resp_valid rising 2 cycles after acceptance.
- Word store 16'h1234 to A=8'hFF: writes 34 at FF and 12 at 00. A word load from FF returns 16'h1234.
- Back-pressure: hold resp_ready=0 for 5 cycles after a load. resp_valid/resp_data must stay stable, req_ready must stay 0, and a concurrent req_valid must not be accepted.
- With LSU_BYTE_ACCESS_EN defined: byte store 8'hA5 to A=8'h02 touches only addr 02. A byte load from A=8'h02 returns 16'h00A5, with resp_valid 1 cycle after acceptance.
- Without LSU_BYTE_ACCESS_EN: the same byte request with req_size=0 performs a full word access at 02/03.
